// File: rtl/hp48_bus_ctrl.sv
// HP48 nibble bus master: sequences one CPU request into BUSCMD cycles
// and gathers read nibbles plus the OR-ed device active lines.
`ifndef BUSCMD_NOP
`define BUSCMD_NOP       4'h0
`define BUSCMD_ID        4'h1
`define BUSCMD_PC_READ   4'h2
`define BUSCMD_DP_READ   4'h3
`define BUSCMD_PC_WRITE  4'h4
`define BUSCMD_DP_WRITE  4'h5
`define BUSCMD_LOAD_PC   4'h6
`define BUSCMD_LOAD_DP   4'h7
`define BUSCMD_CONFIGURE 4'h8
`define BUSCMD_RESET     4'h9
`endif

module hp48_bus_ctrl #(
    parameter int MAX_NIB = 16,
    parameter int LEN_W   = 4
) (
    input  logic                 strobe,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic                 req_use_pc,
    input  logic [19:0]          req_addr,
    input  logic [LEN_W-1:0]     req_len,
    input  logic [4*MAX_NIB-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [4*MAX_NIB-1:0] rsp_rdata,
    output logic                 rsp_error,
    output logic [3:0]           bus_command,
    output logic [19:0]          bus_address,
    output logic [3:0]           bus_nibble_out,
    input  logic [3:0]           bus_nibble_in,
    input  logic                 bus_active
);

    localparam int DW = 4 * MAX_NIB;
    localparam int IW = (MAX_NIB > 1) ? $clog2(MAX_NIB) : 1;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_CFG   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_XFER,
        S_DRAIN,
        S_CFG_LEN,
        S_CFG_ADDR,
        S_BRST,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q;
    logic            use_pc_q;
    logic [19:0]     addr_q;
    logic [IW-1:0]   len_q;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   wdata_q;
    logic            cap_vld_q;
    logic            cap_act_q;
    logic [IW-1:0]   cap_idx_q;

    logic [3:0]      cmd_d;
    logic [19:0]     baddr_d;
    logic [3:0]      nib_d;
    logic [3:0]      xfer_cmd;
    logic [IW-1:0]   len_n;
    logic            accept;
    logic            is_write;

    assign accept   = (state_q == S_IDLE) && req_valid;
    assign is_write = (op_q == OP_WRITE);

    // Oversized lengths saturate at the widest transfer.
    assign len_n = (32'(req_len) > 32'(MAX_NIB - 1)) ?
                   IW'(MAX_NIB - 1) : IW'(req_len);

    always_comb begin
        xfer_cmd = `BUSCMD_DP_READ;
        unique case ({is_write, use_pc_q})
            2'b00: xfer_cmd = `BUSCMD_DP_READ;
            2'b01: xfer_cmd = `BUSCMD_PC_READ;
            2'b10: xfer_cmd = `BUSCMD_DP_WRITE;
            2'b11: xfer_cmd = `BUSCMD_PC_WRITE;
            default: xfer_cmd = `BUSCMD_DP_READ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cmd_d   = `BUSCMD_NOP;
        baddr_d = bus_address;
        nib_d   = 4'h0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    unique case (req_op)
                        OP_READ, OP_WRITE: begin
                            state_d = S_LOAD;
                            cmd_d   = req_use_pc ? `BUSCMD_LOAD_PC
                                                 : `BUSCMD_LOAD_DP;
                            baddr_d = req_addr;
                        end
                        OP_CFG: begin
                            state_d = S_CFG_LEN;
                            cmd_d   = `BUSCMD_CONFIGURE;
                            baddr_d = req_wdata[19:0];
                        end
                        default: begin
                            state_d = S_BRST;
                            cmd_d   = `BUSCMD_RESET;
                        end
                    endcase
                end
            end
            S_LOAD: begin
                state_d = S_XFER;
                idx_d   = '0;
                cmd_d   = xfer_cmd;
                nib_d   = is_write ? wdata_q[3:0] : 4'h0;
            end
            S_XFER: begin
                if (idx_q == len_q) begin
                    state_d = is_write ? S_DONE : S_DRAIN;
                end else begin
                    idx_d = idx_q + IW'(1);
                    cmd_d = xfer_cmd;
                    nib_d = is_write ? wdata_q[{idx_d, 2'b00} +: 4] : 4'h0;
                end
            end
            S_DRAIN:    state_d = S_DONE;
            S_CFG_LEN: begin
                state_d = S_CFG_ADDR;
                cmd_d   = `BUSCMD_CONFIGURE;
                baddr_d = addr_q;
            end
            S_CFG_ADDR: state_d = S_DONE;
            S_BRST:     state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge strobe or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            op_q           <= OP_READ;
            use_pc_q       <= 1'b0;
            addr_q         <= '0;
            len_q          <= '0;
            wdata_q        <= '0;
            cap_vld_q      <= 1'b0;
            cap_act_q      <= 1'b0;
            cap_idx_q      <= '0;
            bus_command    <= `BUSCMD_NOP;
            bus_address    <= '0;
            bus_nibble_out <= '0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_error      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            bus_command    <= cmd_d;
            bus_address    <= baddr_d;
            bus_nibble_out <= nib_d;
            req_ready      <= (state_d == S_IDLE);
            rsp_valid      <= (state_d == S_DONE);
            if (accept) begin
                op_q      <= req_op;
                use_pc_q  <= req_use_pc;
                addr_q    <= req_addr;
                len_q     <= len_n;
                wdata_q   <= req_wdata;
                rsp_rdata <= '0;
                rsp_error <= 1'b0;
            end
            // Device registers nibble_out on this edge; capture it next edge.
            cap_vld_q <= (state_q == S_XFER) && !is_write;
            cap_idx_q <= idx_q;
            cap_act_q <= bus_active;
            if (state_q == S_XFER && !bus_active)
                rsp_error <= 1'b1;
            if (cap_vld_q && cap_act_q)
                rsp_rdata[{cap_idx_q, 2'b00} +: 4] <= bus_nibble_in;
        end
    end

endmodule

// File: tb/tb_hp48_bus_ctrl.sv
// Bench for hp48_bus_ctrl: one sys_ram-like device on the bus, a
// transaction-level memory model, and a per-cycle compare process.
module tb_hp48_bus_ctrl;

    localparam logic [3:0] C_NOP      = 4'h0;
    localparam logic [3:0] C_PC_READ  = 4'h2;
    localparam logic [3:0] C_DP_READ  = 4'h3;
    localparam logic [3:0] C_PC_WRITE = 4'h4;
    localparam logic [3:0] C_DP_WRITE = 4'h5;
    localparam logic [3:0] C_LOAD_PC  = 4'h6;
    localparam logic [3:0] C_LOAD_DP  = 4'h7;
    localparam logic [3:0] C_CONF     = 4'h8;
    localparam logic [3:0] C_RESET    = 4'h9;

    localparam logic [1:0] RD = 2'd0, WR = 2'd1, CF = 2'd2, BR = 2'd3;

    logic        strobe = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic        req_use_pc = 1'b0;
    logic [19:0] req_addr = 20'h0;
    logic [3:0]  req_len = 4'h0;
    logic [63:0] req_wdata = 64'h0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_error;
    logic [3:0]  bus_command;
    logic [19:0] bus_address;
    logic [3:0]  bus_nibble_out;
    logic [3:0]  bus_nibble_in;
    logic        bus_active;

    int tests = 0;
    int fails = 0;

    hp48_bus_ctrl #(.MAX_NIB(16), .LEN_W(4)) dut (
        .strobe(strobe), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_use_pc(req_use_pc),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .bus_command(bus_command), .bus_address(bus_address),
        .bus_nibble_out(bus_nibble_out), .bus_nibble_in(bus_nibble_in),
        .bus_active(bus_active)
    );

    always #5 strobe = ~strobe;

    // ---------------- device on the bus ----------------
    logic [3:0]  dev_mem [0:65535];
    logic [19:0] dev_pc = 20'h0, dev_dp = 20'h0;
    logic [19:0] dev_len = 20'h0, dev_base = 20'h0;
    logic        dev_cfg = 1'b0, dev_phase = 1'b0;
    logic [3:0]  dev_nib = 4'h0;
    logic [19:0] dev_ptr;
    logic        dev_hit, dev_rw;

    initial for (int i = 0; i < 65536; i++) dev_mem[i] = 4'h0;

    assign dev_ptr = (bus_command == C_PC_READ || bus_command == C_PC_WRITE)
                     ? dev_pc : dev_dp;
    assign dev_rw  = bus_command inside {C_PC_READ, C_DP_READ,
                                         C_PC_WRITE, C_DP_WRITE};
    assign dev_hit = dev_cfg && ((dev_ptr & dev_len) == dev_base);
    assign bus_active    = dev_rw && dev_hit;
    assign bus_nibble_in = dev_nib;

    always @(posedge strobe) begin
        dev_nib <= 4'h0;
        case (bus_command)
            C_LOAD_PC: dev_pc <= bus_address;
            C_LOAD_DP: dev_dp <= bus_address;
            C_PC_READ, C_DP_READ: begin
                if (dev_hit) dev_nib <= dev_mem[dev_ptr[15:0]];
            end
            C_PC_WRITE, C_DP_WRITE: begin
                if (dev_hit) dev_mem[dev_ptr[15:0]] <= bus_nibble_out;
            end
            C_CONF: begin
                if (!dev_phase) begin
                    dev_len <= bus_address; dev_phase <= 1'b1;
                end else begin
                    dev_base <= bus_address; dev_cfg <= 1'b1; dev_phase <= 1'b0;
                end
            end
            C_RESET: begin dev_cfg <= 1'b0; dev_phase <= 1'b0; end
            default: ;
        endcase
        if (bus_command == C_PC_READ || bus_command == C_PC_WRITE)
            dev_pc <= dev_pc + 20'h1;
        if (bus_command == C_DP_READ || bus_command == C_DP_WRITE)
            dev_dp <= dev_dp + 20'h1;
    end

    // ---------------- transaction-level model ----------------
    logic [3:0]  m_mem [int];
    logic [19:0] m_mask = 20'h0, m_base = 20'h0;
    logic        m_cfg = 1'b0;

    function automatic logic m_mapped(input logic [19:0] a);
        return m_cfg && ((a & m_mask) == m_base);
    endfunction

    typedef struct {
        logic [3:0]  cmd;
        logic        ca;
        logic [19:0] addr;
        logic        cn;
        logic [3:0]  nib;
        logic        rdy;
        logic        vld;
        logic        cr;
        logic [63:0] rd;
        logic        er;
    } exp_t;

    exp_t expq[$];

    function automatic exp_t mk(input logic [3:0] c, input logic ca,
                                input logic [19:0] a, input logic cn,
                                input logic [3:0] n);
        exp_t e;
        e.cmd = c; e.ca = ca; e.addr = a; e.cn = cn; e.nib = n;
        e.rdy = 1'b0; e.vld = 1'b0; e.cr = 1'b0; e.rd = '0; e.er = 1'b0;
        return e;
    endfunction

    function automatic void push_done(input logic [63:0] rd, input logic er);
        exp_t e;
        e = mk(C_NOP, 1'b0, 20'h0, 1'b0, 4'h0);
        e.vld = 1'b1; e.cr = 1'b1; e.rd = rd; e.er = er;
        expq.push_back(e);
    endfunction

    // Expected per-cycle bus activity and response for one request.
    function automatic void model_req(input logic [1:0] op, input logic pc,
                                      input logic [19:0] a, input logic [3:0] len,
                                      input logic [63:0] wd);
        int n;
        logic [63:0] rd;
        logic er;
        logic [19:0] p;
        n = int'(len) + 1;
        rd = '0;
        er = 1'b0;
        case (op)
            RD, WR: begin
                expq.push_back(mk(pc ? C_LOAD_PC : C_LOAD_DP, 1'b1, a, 1'b0, 4'h0));
                for (int k = 0; k < n; k++) begin
                    p = a + 20'(k);
                    if (op == RD) begin
                        expq.push_back(mk(pc ? C_PC_READ : C_DP_READ,
                                          1'b0, 20'h0, 1'b0, 4'h0));
                        if (m_mapped(p))
                            rd[4*k +: 4] = m_mem.exists(int'(p)) ? m_mem[int'(p)] : 4'h0;
                        else
                            er = 1'b1;
                    end else begin
                        expq.push_back(mk(pc ? C_PC_WRITE : C_DP_WRITE,
                                          1'b0, 20'h0, 1'b1, wd[4*k +: 4]));
                        if (m_mapped(p)) m_mem[int'(p)] = wd[4*k +: 4];
                        else er = 1'b1;
                    end
                end
                if (op == RD) expq.push_back(mk(C_NOP, 1'b0, 20'h0, 1'b0, 4'h0));
            end
            CF: begin
                expq.push_back(mk(C_CONF, 1'b1, wd[19:0], 1'b0, 4'h0));
                expq.push_back(mk(C_CONF, 1'b1, a, 1'b0, 4'h0));
                m_mask = wd[19:0]; m_base = a; m_cfg = 1'b1;
            end
            default: begin
                expq.push_back(mk(C_RESET, 1'b0, 20'h0, 1'b0, 4'h0));
                m_cfg = 1'b0;
            end
        endcase
        push_done(rd, er);
    endfunction

    // ---------------- per-cycle compare ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge strobe);
            if (expq.size() > 0) e = expq.pop_front();
            else begin
                e = mk(C_NOP, 1'b0, 20'h0, 1'b0, 4'h0);
                e.rdy = 1'b1;
            end
            tests++;
            if (bus_command !== e.cmd || (e.ca && bus_address !== e.addr) ||
                (e.cn && bus_nibble_out !== e.nib) || req_ready !== e.rdy ||
                rsp_valid !== e.vld ||
                (e.cr && (rsp_rdata !== e.rd || rsp_error !== e.er))) begin
                fails++;
                $display("FAIL cycle t=%0t cmd %h want %h addr %h want %h nib %h want %h rdy %b want %b vld %b want %b rdata %h want %h err %b want %b",
                         $time, bus_command, e.cmd, bus_address, e.addr,
                         bus_nibble_out, e.nib, req_ready, e.rdy, rsp_valid,
                         e.vld, rsp_rdata, e.rd, rsp_error, e.er);
            end
        end
    end

    // ---------------- driver ----------------
    logic [63:0] last_rd;
    logic        last_er;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic start_req(input logic [1:0] op, input logic pc,
                             input logic [19:0] a, input logic [3:0] len,
                             input logic [63:0] wd);
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < 50; w++) begin
            @(negedge strobe);
            if (req_ready === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL ready_timeout got 0 want 1");
            return;
        end
        #1;
        req_valid = 1'b1; req_op = op; req_use_pc = pc;
        req_addr = a; req_len = len; req_wdata = wd;
        @(posedge strobe);
        #1;
        req_valid = 1'b0;
        model_req(op, pc, a, len, wd);
    endtask

    task automatic wait_rsp(input string name, input int want_lat);
        int lat;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge strobe);
            if (rsp_valid === 1'b1) begin
                lat = k; last_rd = rsp_rdata; last_er = rsp_error;
                break;
            end
        end
        tests++;
        if (lat != want_lat) begin
            fails++;
            $display("FAIL %s latency got %0d want %0d", name, lat, want_lat);
        end
    endtask

    task automatic do_req(input string name, input logic [1:0] op,
                          input logic pc, input logic [19:0] a,
                          input logic [3:0] len, input logic [63:0] wd,
                          input int want_lat);
        start_req(op, pc, a, len, wd);
        wait_rsp(name, want_lat);
    endtask

    task automatic idle_reset(input string name);
        @(negedge strobe);
        #1 reset = 1'b0;
        expq.delete();
        #1;
        chk({name, "_cmd"}, 64'(bus_command), 64'(C_NOP));
        chk({name, "_ready"}, 64'(req_ready), 64'h1);
        chk({name, "_valid"}, 64'(rsp_valid), 64'h0);
        chk({name, "_rdata"}, rsp_rdata, 64'h0);
        repeat (2) @(negedge strobe);
        #1 reset = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge strobe);
        #1;
        chk("rst_cmd", 64'(bus_command), 64'(C_NOP));
        chk("rst_ready", 64'(req_ready), 64'h1);
        chk("rst_rdata", rsp_rdata, 64'h0);
        reset = 1'b1;

        do_req("cfg", CF, 1'b0, 20'h80000, 4'd0, 64'hF0000, 3);
        chk("cfg_err", 64'(last_er), 64'h0);

        do_req("wr", WR, 1'b0, 20'h80010, 4'd4, 64'h12345, 7);
        chk("wr_err", 64'(last_er), 64'h0);

        do_req("rd_dp", RD, 1'b0, 20'h80010, 4'd4, 64'h0, 8);
        chk("rd_dp_data", last_rd, 64'h12345);
        chk("rd_dp_err", 64'(last_er), 64'h0);

        do_req("rd_pc", RD, 1'b1, 20'h80010, 4'd4, 64'h0, 8);
        chk("rd_pc_data", last_rd, 64'h12345);

        idle_reset("idle_rst");

        do_req("rd_unmap", RD, 1'b0, 20'h00000, 4'd2, 64'h0, 6);
        chk("rd_unmap_err", 64'(last_er), 64'h1);
        chk("rd_unmap_data", last_rd, 64'h0);

        do_req("wr_strad", WR, 1'b0, 20'h8FFFE, 4'd3, 64'hDCBA, 6);
        chk("wr_strad_err", 64'(last_er), 64'h1);
        do_req("rd_strad", RD, 1'b0, 20'h8FFFE, 4'd3, 64'h0, 7);
        chk("rd_strad_err", 64'(last_er), 64'h1);
        chk("rd_strad_data", last_rd, 64'hBA);

        do_req("wr16", WR, 1'b1, 20'h80020, 4'd15, 64'hFEDCBA9876543210, 18);
        do_req("rd16", RD, 1'b0, 20'h80020, 4'd15, 64'h0, 19);
        chk("rd16_data", last_rd, 64'hFEDCBA9876543210);

        start_req(RD, 1'b0, 20'h80010, 4'd15, 64'h0);
        repeat (4) @(negedge strobe);
        #1 reset = 1'b0;
        expq.delete();
        #1;
        chk("abort_cmd", 64'(bus_command), 64'(C_NOP));
        chk("abort_ready", 64'(req_ready), 64'h1);
        chk("abort_valid", 64'(rsp_valid), 64'h0);
        repeat (2) @(negedge strobe);
        #1 reset = 1'b1;
        do_req("rd_after", RD, 1'b0, 20'h80010, 4'd4, 64'h0, 8);
        chk("rd_after_data", last_rd, 64'h12345);

        do_req("brst", BR, 1'b0, 20'h0, 4'd0, 64'h0, 2);
        do_req("rd_brst", RD, 1'b0, 20'h80010, 4'd4, 64'h0, 8);
        chk("rd_brst_err", 64'(last_er), 64'h1);
        chk("rd_brst_data", last_rd, 64'h0);

        do_req("cfg2", CF, 1'b0, 20'h80000, 4'd0, 64'hF0000, 3);
        do_req("rd_b2b", RD, 1'b0, 20'h80010, 4'd4, 64'h0, 8);
        chk("rd_b2b_data", last_rd, 64'h12345);

        repeat (3) @(negedge strobe);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
